r_station_q: RTL and testbench

- Parametrised successor to the single-group reservation station.
- Buffers up to ENTRIES decoded micro-op groups from ID in a FIFO. Each group carries up to MAX_UOPS uops, PC, a data word and a uop count.
- Presents one uop per cycle to the EX scheduler and advances on ex_sched_ack.
- Adds decoupled feeding (ID may feed while a group executes), variable group length, and a synchronous flush.

---
 rtl/rs_pkg.sv | 25 ++
 rtl/rs_group_fifo.sv | 91 +++++++++
 rtl/r_station_q.sv | 117 +++++++++++
 tb/tb_r_station_q.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station: NOP encoding, count-width helper
// and the default-width entry layout.
package rs_pkg;

  localparam int RS_UOP_W    = 20;
  localparam int RS_MAX_UOPS = 3;
  localparam int RS_DATA_W   = 16;

  localparam logic [19:0] NOP = 20'b0000_0000_1111_00_000_000;

  function automatic int cnt_w(input int max_uops);
    return $clog2(max_uops + 1);
  endfunction

  localparam int RS_CNT_W = cnt_w(RS_MAX_UOPS);

  // Field order matters: data sits in the LSBs so the FIFO can patch it generically.
  typedef struct packed {
    logic [RS_MAX_UOPS*RS_UOP_W-1:0] uops;
    logic [RS_CNT_W-1:0]             count;
    logic [RS_DATA_W-1:0]            pc;
    logic [RS_DATA_W-1:0]            data;
  } rs_entry_t;

endpackage

// File: rtl/rs_group_fifo.sv
// Generic ENTRIES-deep FIFO of packed entries with flush, occupancy counter and a
// write port that overwrites the low DATA_W bits of the head entry.
module rs_group_fifo #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 2,
  parameter int DATA_W  = 16
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             head_wr,
  input  logic [DATA_W-1:0] head_wr_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int OCC_W = $clog2(ENTRIES + 1);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full  = (occ_q == OCC_W'(ENTRIES));
  assign empty = (occ_q == {OCC_W{1'b0}});
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush wins over everything.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      occ_d    = {OCC_W{1'b0}};
    end else begin
      // A head write racing a pop lands on the departing entry, so it is simply dropped.
      if (head_wr && !empty && !pop) begin
        mem_d[rd_ptr_q][DATA_W-1:0] = head_wr_data;
      end else begin
        mem_d[rd_ptr_q] = mem_q[rd_ptr_q];
      end
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/r_station_q.sv
// Reservation station queue: buffers decoded uop groups and issues one uop per cycle
// to the EX scheduler, with head data-word bypass and synchronous flush.
module r_station_q import rs_pkg::*; #(
  parameter int  UOP_W    = 20,
  parameter int  MAX_UOPS = 3,
  parameter int  ENTRIES  = 2,
  parameter int  DATA_W   = 16,
  localparam int CNT_W    = cnt_w(MAX_UOPS)
) (
  input  logic                      clk,
  input  logic                      a_rst,
  input  logic                      flush,
  input  logic                      id_feed_valid,
  output logic                      id_feed_ready,
  input  logic [DATA_W-1:0]         id_pc,
  input  logic [MAX_UOPS*UOP_W-1:0] id_uops,
  input  logic [CNT_W-1:0]          id_uop_count,
  input  logic [DATA_W-1:0]         id_k16,
  input  logic [DATA_W-1:0]         mem_data_in,
  input  logic                      mem_data_wr,
  input  logic                      ex_sched_ack,
  output logic [UOP_W-1:0]          ex_uop_next,
  output logic                      ex_uop_last,
  output logic                      ex_is_valid,
  output logic [DATA_W-1:0]         ex_data_out,
  output logic [DATA_W-1:0]         ex_pc
);

  // Same layout as rs_entry_t, resized to this instance's parameters.
  typedef struct packed {
    logic [MAX_UOPS*UOP_W-1:0] uops;
    logic [CNT_W-1:0]          count;
    logic [DATA_W-1:0]         pc;
    logic [DATA_W-1:0]         data;
  } entry_t;

  localparam int              ENTRY_W = $bits(entry_t);
  localparam logic [UOP_W-1:0] NOP_UOP = UOP_W'(NOP);

  entry_t             push_entry_s;
  entry_t             head_s;
  logic [ENTRY_W-1:0] head_raw_s;
  logic               full_s, empty_s;
  logic               push_s, pop_s, advance_s, last_s;
  logic [UOP_W-1:0]   uop_sel_s;
  logic [CNT_W-1:0]   idx_q, idx_d;

  rs_group_fifo #(
    .WIDTH   (ENTRY_W),
    .ENTRIES (ENTRIES),
    .DATA_W  (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .a_rst        (a_rst),
    .flush        (flush),
    .push         (push_s),
    .push_data    (push_entry_s),
    .pop          (pop_s),
    .head_wr      (mem_data_wr),
    .head_wr_data (mem_data_in),
    .head         (head_raw_s),
    .full         (full_s),
    .empty        (empty_s)
  );

  assign head_s = head_raw_s;

  // Handshake, advance/pop decision and next head index.
  always_comb begin
    push_entry_s.uops  = id_uops;
    push_entry_s.count = id_uop_count;
    push_entry_s.pc    = id_pc;
    push_entry_s.data  = id_k16;
    advance_s     = ex_sched_ack & ~empty_s;
    last_s        = ~empty_s & (idx_q == head_s.count - CNT_W'(1));
    pop_s         = advance_s & last_s;
    id_feed_ready = ~full_s | pop_s;
    // Zero-length groups complete the handshake but are never stored.
    push_s = id_feed_valid & id_feed_ready & (id_uop_count != {CNT_W{1'b0}}) & ~flush;
    if (flush) begin
      idx_d = {CNT_W{1'b0}};
    end else if (advance_s) begin
      idx_d = last_s ? {CNT_W{1'b0}} : idx_q + CNT_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Uop select and EX-facing outputs, gated to reset values while empty.
  always_comb begin
    uop_sel_s = NOP_UOP;
    for (int i = 0; i < MAX_UOPS; i++) begin
      uop_sel_s = (idx_q == CNT_W'(i)) ? head_s.uops[i*UOP_W +: UOP_W] : uop_sel_s;
    end
    ex_is_valid = ~empty_s;
    ex_uop_last = last_s;
    ex_uop_next = empty_s ? NOP_UOP : uop_sel_s;
    ex_pc       = empty_s ? {DATA_W{1'b0}} : head_s.pc;
    if (empty_s) begin
      ex_data_out = {DATA_W{1'b0}};
    end else if (mem_data_wr) begin
      ex_data_out = mem_data_in;
    end else begin
      ex_data_out = head_s.data;
    end
  end

  // Head uop index register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      idx_q <= {CNT_W{1'b0}};
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: tb/tb_r_station_q.sv
// Directed scoreboard bench for r_station_q (default parameters).
module tb_r_station_q;
  import rs_pkg::*;

  logic        clk;
  logic        a_rst;
  logic        flush;
  logic        id_feed_valid;
  logic        id_feed_ready;
  logic [15:0] id_pc;
  logic [59:0] id_uops;
  logic [1:0]  id_uop_count;
  logic [15:0] id_k16;
  logic [15:0] mem_data_in;
  logic        mem_data_wr;
  logic        ex_sched_ack;
  logic [19:0] ex_uop_next;
  logic        ex_uop_last;
  logic        ex_is_valid;
  logic [15:0] ex_data_out;
  logic [15:0] ex_pc;

  typedef struct {
    logic [19:0] uop;
    logic        last;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [19:0] NOP_EXP = 20'h00F00;
  localparam logic [19:0] UA = 20'h1000A, UB = 20'h2000B, UC = 20'h3000C;
  localparam logic [19:0] UD = 20'h4000D, UE = 20'h5000E, UF = 20'h6000F;
  localparam logic [19:0] UG = 20'h70011, UH = 20'h80022, UI = 20'h90033;
  localparam logic [19:0] UJ = 20'hA0044, UK = 20'hB0055;

  r_station_q dut (
    .clk           (clk),
    .a_rst         (a_rst),
    .flush         (flush),
    .id_feed_valid (id_feed_valid),
    .id_feed_ready (id_feed_ready),
    .id_pc         (id_pc),
    .id_uops       (id_uops),
    .id_uop_count  (id_uop_count),
    .id_k16        (id_k16),
    .mem_data_in   (mem_data_in),
    .mem_data_wr   (mem_data_wr),
    .ex_sched_ack  (ex_sched_ack),
    .ex_uop_next   (ex_uop_next),
    .ex_uop_last   (ex_uop_last),
    .ex_is_valid   (ex_is_valid),
    .ex_data_out   (ex_data_out),
    .ex_pc         (ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Illegal group lengths must never be offered.
  always @(posedge clk) begin
    if (a_rst === 1'b1 && id_feed_valid === 1'b1) begin
      checks++;
      assert (id_uop_count <= 2'd3) else begin
        failures++;
        $error("FAIL illegal_count observed=%0d expected<=3", id_uop_count);
      end
    end
  end

  task automatic feed(input logic [15:0] pc, input logic [1:0] cnt, input logic [19:0] u0,
                      input logic [19:0] u1, input logic [19:0] u2, input logic [15:0] k);
    id_feed_valid = 1'b1;
    id_pc         = pc;
    id_uop_count  = cnt;
    id_uops       = {u2, u1, u0};
    id_k16        = k;
  endtask

  task automatic sb_push(input logic [15:0] pc, input logic [1:0] cnt, input logic [19:0] u0,
                         input logic [19:0] u1, input logic [19:0] u2);
    logic [19:0] u[3];
    u[0] = u0; u[1] = u1; u[2] = u2;
    for (int i = 0; i < int'(cnt); i++) begin
      sb.push_back('{u[i], (i == int'(cnt) - 1), pc});
    end
  endtask

  task automatic sb_check(input string tag, input bit consume);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = consume ? sb.pop_front() : sb[0];
      chk({tag, "_valid"}, 32'(ex_is_valid), 32'd1);
      chk({tag, "_uop"},   32'(ex_uop_next), 32'(e.uop));
      chk({tag, "_last"},  32'(ex_uop_last), 32'(e.last));
      chk({tag, "_pc"},    32'(ex_pc),       32'(e.pc));
    end
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(ex_is_valid), 32'd0);
    chk({tag, "_uop"},   32'(ex_uop_next), 32'(NOP_EXP));
    chk({tag, "_last"},  32'(ex_uop_last), 32'd0);
    chk({tag, "_pc"},    32'(ex_pc),       32'd0);
    chk({tag, "_data"},  32'(ex_data_out), 32'd0);
  endtask

  initial begin
    a_rst = 1'b0; flush = 1'b0; id_feed_valid = 1'b0; id_pc = 16'h0000;
    id_uops = 60'h0; id_uop_count = 2'd0; id_k16 = 16'h0000;
    mem_data_in = 16'h0000; mem_data_wr = 1'b0; ex_sched_ack = 1'b0;
    #3;
    chk_empty("rst");
    chk("rst_ready", 32'(id_feed_ready), 32'd1);
    @(negedge clk); a_rst = 1'b1;

    @(negedge clk); #1;
    chk_empty("idle");
    chk("idle_ready", 32'(id_feed_ready), 32'd1);

    // Group 1: three uops acked back to back.
    @(negedge clk);
    feed(16'h1234, 2'd3, UA, UB, UC, 16'h00FF);
    sb_push(16'h1234, 2'd3, UA, UB, UC);
    #1;
    chk("g1_ready", 32'(id_feed_ready), 32'd1);
    chk("g1_latency", 32'(ex_is_valid), 32'd0);
    @(negedge clk); id_feed_valid = 1'b0; ex_sched_ack = 1'b1; #1;
    sb_check("g1_a", 1'b1);
    chk("g1_data", 32'(ex_data_out), 32'h00FF);
    @(negedge clk); #1;
    sb_check("g1_b", 1'b1);
    @(negedge clk); #1;
    sb_check("g1_c", 1'b1);
    @(negedge clk); ex_sched_ack = 1'b0; #1;
    chk_empty("g1_done");

    // Fill to depth, then pop while full with a third group offered.
    @(negedge clk);
    feed(16'h2000, 2'd2, UD, UE, 20'h0, 16'h1111);
    sb_push(16'h2000, 2'd2, UD, UE, 20'h0);
    #1; chk("g2_ready", 32'(id_feed_ready), 32'd1);
    @(negedge clk);
    feed(16'h3000, 2'd1, UF, 20'h0, 20'h0, 16'h3333);
    sb_push(16'h3000, 2'd1, UF, 20'h0, 20'h0);
    #1; chk("g3_ready", 32'(id_feed_ready), 32'd1);
    sb_check("g2_d_hold", 1'b0);
    @(negedge clk);
    feed(16'h4000, 2'd2, UG, UH, 20'h0, 16'h4444);
    mem_data_wr = 1'b1; mem_data_in = 16'hBEEF; #1;
    chk("full_ready", 32'(id_feed_ready), 32'd0);
    chk("bypass", 32'(ex_data_out), 32'hBEEF);
    sb_check("g2_d_full", 1'b0);
    @(negedge clk); mem_data_wr = 1'b0; ex_sched_ack = 1'b1; #1;
    chk("full_ready_mid", 32'(id_feed_ready), 32'd0);
    chk("wr_stored", 32'(ex_data_out), 32'hBEEF);
    sb_check("g2_d", 1'b1);
    @(negedge clk); mem_data_wr = 1'b1; mem_data_in = 16'hDEAD; #1;
    chk("pop_push_ready", 32'(id_feed_ready), 32'd1);
    chk("pop_bypass", 32'(ex_data_out), 32'hDEAD);
    sb_check("g2_e", 1'b1);
    sb_push(16'h4000, 2'd2, UG, UH, 20'h0);
    @(negedge clk); id_feed_valid = 1'b0; mem_data_wr = 1'b0; #1;
    sb_check("g3_f", 1'b1);
    chk("g3_own_k16", 32'(ex_data_out), 32'h3333);
    @(negedge clk); #1;
    sb_check("g4_g", 1'b1);
    chk("g4_data", 32'(ex_data_out), 32'h4444);

    // Flush mid-group together with a valid feed.
    @(negedge clk); ex_sched_ack = 1'b0; flush = 1'b1;
    feed(16'h5000, 2'd1, UI, 20'h0, 20'h0, 16'h5555); #1;
    sb_check("g4_h_pre_flush", 1'b0);
    chk("flush_ready", 32'(id_feed_ready), 32'd1);
    @(negedge clk); flush = 1'b0; id_feed_valid = 1'b0; sb.delete(); #1;
    chk_empty("flushed");
    @(negedge clk); #1;
    chk("flush_drop", 32'(ex_is_valid), 32'd0);

    // Zero-length group, then ack and data write while empty.
    @(negedge clk); feed(16'h7000, 2'd0, UA, 20'h0, 20'h0, 16'h7777); #1;
    chk("zero_ready", 32'(id_feed_ready), 32'd1);
    @(negedge clk); id_feed_valid = 1'b0; ex_sched_ack = 1'b1;
    mem_data_wr = 1'b1; mem_data_in = 16'hAAAA; #1;
    chk("zero_not_stored", 32'(ex_is_valid), 32'd0);
    chk("empty_data_gate", 32'(ex_data_out), 32'd0);
    @(negedge clk); ex_sched_ack = 1'b0; mem_data_wr = 1'b0;
    feed(16'h6000, 2'd2, UJ, UK, 20'h0, 16'h6666);
    sb_push(16'h6000, 2'd2, UJ, UK, 20'h0); #1;
    chk("g6_latency", 32'(ex_is_valid), 32'd0);
    @(negedge clk); id_feed_valid = 1'b0; ex_sched_ack = 1'b1; #1;
    sb_check("g6_j", 1'b1);
    chk("g6_data", 32'(ex_data_out), 32'h6666);
    @(negedge clk); ex_sched_ack = 1'b0; #1;
    sb_check("g6_k", 1'b0);

    // Asynchronous reset mid-group.
    #1; a_rst = 1'b0; #1;
    chk_empty("async_rst");
    chk("async_rst_ready", 32'(id_feed_ready), 32'd1);
    @(negedge clk); a_rst = 1'b1; sb.delete();
    @(negedge clk); #1;
    chk("post_rst_empty", 32'(ex_is_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
